dmem_vec_responder: RTL and testbench
=====================================

# dmem_vec_responder

Data-memory responder for the single-cycle core's load/store port. It services scalar loads and stores, and accepts 5-lane vector stores. Each vector store is serialised into a single-write-port word array over five cycles, and the block holds the core with `Stall` while the burst runs. It sits on the memory side of the core's `MemWrite`/`ALUResult`/`WriteData`/`VecWriteData_0..4`/`ReadData` interface.

## Interface
- `DEPTH`, 64: number of 32-bit words. Must be a power of two, at least 8.
- `ADDR_W`, log2(DEPTH): word-index width. Derived from `DEPTH`; not overridden.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  reset, asynchronous, active-low.
- `MemWrite`  in  1  store request.
- `VecWrite`  in  1  qualifies a store as a 5-lane vector store.
- `Addr`  in  32  byte address, driven from the core's `ALUResult`.
- `WriteData`  in  32  scalar store data.
- `VecWriteData_0` .. `VecWriteData_4`  in  32 each  vector lanes 0..4.
- `ReadData`  out  32  load data.
- `Stall`  out  1  core must freeze PC and hold its inputs.
- `MisalignErr`  out  1  sticky flag: a misaligned store was seen.

## Operation
- Word index: `idx = Addr[ADDR_W+1:2]`. Upper address bits are ignored, so the array aliases.
- Misaligned store: `Addr[1:0] != 0` with `MemWrite=1`.
  - The store is dropped, scalar or vector; no burst starts.
  - `MisalignErr` sets and stays set until reset.
- FSM has two states, IDLE and BURST, plus a 3-bit lane counter `k`, a base-index register and five 32-bit lane holding registers.
- In IDLE, scalar store (`MemWrite=1`, `VecWrite=0`, aligned): `mem[idx] <= WriteData`.
- In IDLE, vector store (`MemWrite=1`, `VecWrite=1`, aligned):
  - Latch `idx` and all five lanes.
  - Write lane 0 to `mem[idx]`.
  - Set `k=1` and go to BURST.
- In BURST, each edge:
  - Write lane k to `mem[(base+k) mod DEPTH]`. The index wraps modulo DEPTH.
  - Increment `k`.
  - After lane 4 is written, go to IDLE with `k=0`.
- In BURST, `MemWrite`, `VecWrite`, `Addr` and all write data are ignored. A new request is only sampled in IDLE.
- `VecWrite=1` with `MemWrite=0` is a no-op.
- `ReadData = mem[idx]`: asynchronous, combinational read of the array, in every state.
- `Stall = (state == BURST)`. It is decoded from registered state only; there is no input-to-`Stall` combinational path.
- Reset (`reset=0`):
  - State goes to IDLE; `k`, base and lane registers clear to 0.
  - `Stall=0`, `MisalignErr=0`.
  - Array contents are not cleared. `ReadData` shows array contents, undefined until written.
- Reset during BURST aborts the burst:
  - Lanes already written remain.
  - Remaining lanes are never written.
  - `Stall` deasserts asynchronously.

## Timing
- Scalar store: write lands at the sampling edge. A load from the same address in the next cycle returns the new data.
- Vector store, accepted at edge E0: lanes 0..4 land at E0..E4. `Stall` is high from E0 until E4, four cycles. The next request is sampled at E5.
- Write-to-read within a cycle: `ReadData` reflects a write only after its edge. There is no same-cycle bypass of the incoming `WriteData`.
- Store latency is 1 edge for scalar and 5 edges for vector. Load latency is 0, combinational.

## Configuration
- Macro: `DMEM_VEC_BURST_FWD_EN`.
- Defined: while in BURST, a load whose `idx` equals `(base+j) mod DEPTH` for a not-yet-written lane j (j ≥ k) returns that held lane value instead of the stale array word.
- Undefined: `ReadData` is always the raw array word, so pending lanes read stale data.
- Either way, `Stall` and write behaviour are identical.

## Test plan
- Scalar store, aligned: deassert reset, then store `Addr=0x10`, `WriteData=0xDEADBEEF`.
  - Next cycle, with `Addr=0x10`: `ReadData=0xDEADBEEF`, `Stall=0`.
- Vector store: `Addr=0x20`, lanes `0x11,0x22,0x33,0x44,0x55`.
  - `Stall` is high for exactly 4 cycles.
  - Afterwards, words 8..12 read `0x11..0x55`.
  - A store presented during `Stall` is not performed.
- Wrap-around: `DEPTH=64`, vector store at `Addr=0xF8`, lanes `A0..A4`.
  - Words 62, 63, 0, 1, 2 hold `A0..A4`.
- Misaligned store: scalar store at `Addr=0x22`, then vector store at `Addr=0x41`.
  - Neither store writes; no burst starts.
  - `MisalignErr=1`, and it stays 1 until reset.
- Reset mid-burst: vector store at `0x40`; drive `reset=0` after E2.
  - `Stall` drops immediately.
  - Words 16..18 hold lanes 0..2; words 19..20 keep prior values.
- Forwarding: during a burst at `0x80`, read `Addr=0x90` (lane 4) in cycle E1.
  - With `DMEM_VEC_BURST_FWD_EN`: lane-4 value.
  - Without the macro: the old word.

Source files
------------

// File: rtl/dmem_vec_responder_if.sv
// ----------------------------------------------------------------------------
// dmem_vec_responder_if
//   Load/store bus between the single-cycle core (master) and the data-memory
//   responder (slave).
//
//   Signals (core perspective):
//     MemWrite         out  store request
//     VecWrite         out  qualifies a store as a 5-lane vector store
//     Addr[31:0]       out  byte address (core ALUResult)
//     WriteData[31:0]  out  scalar store data
//     VecWriteData_0..4 out vector store lanes 0..4
//     ReadData[31:0]   in   combinational load data
//     Stall            in   core must freeze PC and hold its request
//     MisalignErr      in   sticky misaligned-store flag
// ----------------------------------------------------------------------------
interface dmem_vec_responder_if;
    logic        MemWrite;
    logic        VecWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] VecWriteData_0;
    logic [31:0] VecWriteData_1;
    logic [31:0] VecWriteData_2;
    logic [31:0] VecWriteData_3;
    logic [31:0] VecWriteData_4;
    logic [31:0] ReadData;
    logic        Stall;
    logic        MisalignErr;

    modport master (
        output MemWrite, VecWrite, Addr, WriteData,
        output VecWriteData_0, VecWriteData_1, VecWriteData_2,
        output VecWriteData_3, VecWriteData_4,
        input  ReadData, Stall, MisalignErr
    );

    modport slave (
        input  MemWrite, VecWrite, Addr, WriteData,
        input  VecWriteData_0, VecWriteData_1, VecWriteData_2,
        input  VecWriteData_3, VecWriteData_4,
        output ReadData, Stall, MisalignErr
    );
endinterface

// File: rtl/dmem_vec_responder.sv
// ----------------------------------------------------------------------------
// dmem_vec_responder
//   Data memory for the single-cycle core. Scalar stores write one word at the
//   sampling edge; a 5-lane vector store is captured in one edge and then
//   serialised into the single-write-port array over the following four
//   edges while Stall holds the core. Loads are combinational.
//
//   Ports:
//     clk    in  rising-edge clock
//     reset  in  asynchronous active-low reset
//     bus    slave modport of dmem_vec_responder_if (request in, ReadData,
//            Stall, MisalignErr out)
//
//   Parameters:
//     DEPTH  number of 32-bit words (power of two, >= 8)
//
//   Configuration macro:
//     DMEM_VEC_BURST_FWD_EN  when defined, loads hitting a lane that is still
//                            pending in the current burst return the held
//                            lane value instead of the stale array word.
// ----------------------------------------------------------------------------
module dmem_vec_responder #(
    parameter int unsigned DEPTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    dmem_vec_responder_if.slave   bus
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_k;
    logic [2:0]          w_k_nxt;
    logic [ADDR_W-1:0]   r_base;
    logic [31:0]         r_lane [0:4];
    logic                r_misalign;

    logic [31:0]         r_mem [0:DEPTH-1];

    logic [ADDR_W-1:0]   w_idx;
    logic                w_misaligned;
    logic                w_latch;
    logic                w_we;
    logic [ADDR_W-1:0]   w_waddr;
    logic [31:0]         w_wdata;
    logic                w_misalign_set;
    logic [31:0]         w_rdata;
    logic                w_unused;

    assign w_idx        = bus.Addr[ADDR_W+1:2];
    assign w_misaligned = (bus.Addr[1:0] != 2'b00);
    // Upper address bits alias onto the array.
    assign w_unused     = ^bus.Addr[31:ADDR_W+2];

    // ------------------------------------------------------------------
    // Next-state / write-port decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_k_nxt        = r_k;
        w_latch        = 1'b0;
        w_we           = 1'b0;
        w_waddr        = w_idx;
        w_wdata        = bus.WriteData;
        w_misalign_set = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (bus.MemWrite) begin
                    if (w_misaligned) begin
                        w_misalign_set = 1'b1;
                    end else if (bus.VecWrite) begin
                        w_latch     = 1'b1;
                        w_we        = 1'b1;
                        w_waddr     = w_idx;
                        w_wdata     = bus.VecWriteData_0;
                        w_k_nxt     = 3'd1;
                        w_state_nxt = S_BURST;
                    end else begin
                        w_we    = 1'b1;
                        w_waddr = w_idx;
                        w_wdata = bus.WriteData;
                    end
                end
            end
            S_BURST: begin
                // Request inputs are ignored; only the held lanes are written.
                w_we    = 1'b1;
                w_waddr = r_base + ADDR_W'(r_k);
                case (r_k)
                    3'd1:    w_wdata = r_lane[1];
                    3'd2:    w_wdata = r_lane[2];
                    3'd3:    w_wdata = r_lane[3];
                    3'd4:    w_wdata = r_lane[4];
                    default: w_wdata = r_lane[0];
                endcase
                if (r_k == 3'd4) begin
                    w_k_nxt     = 3'd0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_k_nxt = r_k + 3'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_k_nxt     = 3'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control / holding registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_k        <= '0;
            r_base     <= '0;
            r_misalign <= 1'b0;
            for (int unsigned i = 0; i < 5; i++) begin
                r_lane[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            if (w_latch) begin
                r_base    <= w_idx;
                r_lane[0] <= bus.VecWriteData_0;
                r_lane[1] <= bus.VecWriteData_1;
                r_lane[2] <= bus.VecWriteData_2;
                r_lane[3] <= bus.VecWriteData_3;
                r_lane[4] <= bus.VecWriteData_4;
            end
            if (w_misalign_set) begin
                r_misalign <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Word array: contents survive reset; no write while reset is held.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_we && reset) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Load path
    // ------------------------------------------------------------------
`ifdef DMEM_VEC_BURST_FWD_EN
    // Lanes j >= k have not reached the array yet; serve them from the
    // holding registers so a load never sees the stale word.
    always_comb begin
        w_rdata = r_mem[w_idx];
        if (r_state == S_BURST) begin
            for (int unsigned j = 1; j < 5; j++) begin
                if ((3'(j) >= r_k) && (w_idx == r_base + ADDR_W'(j))) begin
                    w_rdata = r_lane[j];
                end
            end
        end
    end
`else
    always_comb begin
        w_rdata = r_mem[w_idx];
    end
`endif

    assign bus.ReadData    = w_rdata;
    assign bus.Stall       = (r_state == S_BURST);
    assign bus.MisalignErr = r_misalign;

endmodule

// File: tb/tb_dmem_vec_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_vec_responder
//   Directed bench for dmem_vec_responder. Stimulus pushes hand-computed
//   expectations into a queue; a monitor on the falling edge pops them and
//   compares against the live DUT outputs.
// ----------------------------------------------------------------------------
module tb_dmem_vec_responder;

    localparam int K_RDATA = 0;
    localparam int K_STALL = 1;
    localparam int K_MERR  = 2;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    exp_t q[$];

    dmem_vec_responder_if bus ();

    dmem_vec_responder #(.DEPTH(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare every queued expectation at the falling edge.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                case (e.kind)
                    K_RDATA: act = bus.ReadData;
                    K_STALL: act = {31'd0, bus.Stall};
                    default: act = {31'd0, bus.MisalignErr};
                endcase
                vectors++;
                if (act !== e.exp) begin
                    miscompares++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic expect_v(input int kind, input logic [31:0] v, input string name);
        exp_t e;
        e.kind = kind;
        e.exp  = v;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic idle_in();
        bus.MemWrite       = 1'b0;
        bus.VecWrite       = 1'b0;
        bus.WriteData      = '0;
        bus.VecWriteData_0 = '0;
        bus.VecWriteData_1 = '0;
        bus.VecWriteData_2 = '0;
        bus.VecWriteData_3 = '0;
        bus.VecWriteData_4 = '0;
    endtask

    // Called just after a rising edge; the store is sampled at the next edge.
    task automatic scalar_store(input logic [31:0] a, input logic [31:0] d);
        bus.Addr      = a;
        bus.WriteData = d;
        bus.MemWrite  = 1'b1;
        bus.VecWrite  = 1'b0;
        @(posedge clk); #1;
        idle_in();
    endtask

    task automatic vec_present(input logic [31:0] a, input logic [31:0] base_val);
        bus.Addr           = a;
        bus.MemWrite       = 1'b1;
        bus.VecWrite       = 1'b1;
        bus.VecWriteData_0 = base_val;
        bus.VecWriteData_1 = base_val + 32'h1;
        bus.VecWriteData_2 = base_val + 32'h2;
        bus.VecWriteData_3 = base_val + 32'h3;
        bus.VecWriteData_4 = base_val + 32'h4;
    endtask

    task automatic read_chk(input logic [31:0] a, input logic [31:0] v, input string name);
        bus.Addr = a;
        expect_v(K_RDATA, v, name);
        @(posedge clk); #1;
    endtask

    task automatic vec_store_full(input logic [31:0] a, input logic [31:0] base_val);
        vec_present(a, base_val);
        @(posedge clk); #1;              // E0
        idle_in();
        repeat (4) begin
            @(posedge clk); #1;          // E1..E4
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        bus.Addr    = '0;
        idle_in();

        // Reset state
        @(posedge clk); #1;
        expect_v(K_STALL, 32'd0, "reset_stall");
        expect_v(K_MERR,  32'd0, "reset_misalign");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Scalar store and read-back
        scalar_store(32'h10, 32'hDEADBEEF);
        bus.Addr = 32'h10;
        expect_v(K_STALL, 32'd0, "scalar_stall");
        read_chk(32'h10, 32'hDEADBEEF, "scalar_rd");

        // Prefill words used later
        scalar_store(32'h38, 32'h14141414);   // word 14
        scalar_store(32'h40, 32'h16161616);   // word 16
        scalar_store(32'h4C, 32'h19191919);   // word 19
        scalar_store(32'h50, 32'h20202020);   // word 20
        scalar_store(32'h90, 32'h0BAD0036);   // word 36

        // Vector store at 0x20; a store held during Stall must be dropped
        vec_present(32'h20, 32'h11);
        bus.VecWriteData_1 = 32'h22;
        bus.VecWriteData_2 = 32'h33;
        bus.VecWriteData_3 = 32'h44;
        bus.VecWriteData_4 = 32'h55;
        @(posedge clk); #1;                   // E0
        idle_in();
        bus.Addr      = 32'h38;
        bus.MemWrite  = 1'b1;
        bus.WriteData = 32'hBADBAD00;
        expect_v(K_STALL, 32'd1, "vec_stall_c1");
        @(posedge clk); #1;
        expect_v(K_STALL, 32'd1, "vec_stall_c2");
        @(posedge clk); #1;
        expect_v(K_STALL, 32'd1, "vec_stall_c3");
        @(posedge clk); #1;
        expect_v(K_STALL, 32'd1, "vec_stall_c4");
        @(posedge clk); #1;                   // E4
        idle_in();
        expect_v(K_STALL, 32'd0, "vec_stall_end");
        read_chk(32'h20, 32'h11, "vec_w8");
        read_chk(32'h24, 32'h22, "vec_w9");
        read_chk(32'h28, 32'h33, "vec_w10");
        read_chk(32'h2C, 32'h44, "vec_w11");
        read_chk(32'h30, 32'h55, "vec_w12");
        read_chk(32'h38, 32'h14141414, "stall_store_dropped");

        // Wrap-around at word 62
        vec_store_full(32'hF8, 32'hA0);
        read_chk(32'hF8, 32'hA0, "wrap_w62");
        read_chk(32'hFC, 32'hA1, "wrap_w63");
        read_chk(32'h00, 32'hA2, "wrap_w0");
        read_chk(32'h04, 32'hA3, "wrap_w1");
        read_chk(32'h08, 32'hA4, "wrap_w2");
        read_chk(32'h10, 32'hDEADBEEF, "wrap_w4_untouched");
        expect_v(K_MERR, 32'd0, "merr_before");

        // Misaligned stores
        scalar_store(32'h22, 32'h77777777);
        expect_v(K_MERR, 32'd1, "merr_scalar");
        read_chk(32'h20, 32'h11, "misalign_scalar_drop");
        vec_present(32'h41, 32'hE0);
        @(posedge clk); #1;
        idle_in();
        expect_v(K_STALL, 32'd0, "misalign_no_burst");
        read_chk(32'h40, 32'h16161616, "misalign_vec_drop");
        repeat (3) begin
            @(posedge clk); #1;
        end
        expect_v(K_MERR, 32'd1, "merr_sticky");

        // Pending-lane read during a burst at 0x80
        vec_present(32'h80, 32'hF0);
        @(posedge clk); #1;                   // E0, k=1
        idle_in();
        bus.Addr = 32'h90;
`ifdef DMEM_VEC_BURST_FWD_EN
        expect_v(K_RDATA, 32'hF4, "fwd_lane4");
`else
        expect_v(K_RDATA, 32'h0BAD0036, "nofwd_lane4");
`endif
        repeat (4) begin
            @(posedge clk); #1;
        end
        read_chk(32'h90, 32'hF4, "fwd_burst_w36");

        // Reset mid-burst at 0x40
        vec_present(32'h40, 32'hC0);
        @(posedge clk); #1;                   // E0
        idle_in();
        @(posedge clk); #1;                   // E1
        @(posedge clk); #1;                   // E2
        reset = 1'b0;
        #1;
        expect_v(K_STALL, 32'd0, "rst_stall_drop");
        expect_v(K_MERR,  32'd0, "rst_merr_clear");
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        read_chk(32'h40, 32'hC0, "rst_w16");
        read_chk(32'h44, 32'hC1, "rst_w17");
        read_chk(32'h48, 32'hC2, "rst_w18");
        read_chk(32'h4C, 32'h19191919, "rst_w19_kept");
        read_chk(32'h50, 32'h20202020, "rst_w20_kept");
        expect_v(K_STALL, 32'd0, "final_stall");

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL queue_drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
